// File: rtl/fetch_unit_if.sv
// Instruction-fetch handshake bundle: memory request/response plus the
// decoder-facing held-instruction handshake and branch/jump decisions.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        dobranch;
  logic        dojump;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, dobranch, dojump
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, instr_ready, dobranch, dojump
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher: requests the word at pc, holds it
// for the decoder, and redirects pc on the accept cycle (jump > branch > +4).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  fetch_unit_if.master       bus,
  output logic [31:0]        pc,
  output logic [31:0]        pcplus4,
  output logic [31:0]        retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        capture;
  logic [31:0] instr_q;
  logic [31:0] pc_nxt;

  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic [15:0] imm);
    return base + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] base,
                                              input logic [25:0] idx);
    return {base[31:28], idx, 2'b00};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (bus.imem_ack)    state_nxt = HOLD;
      HOLD:    if (bus.instr_ready) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept  = (state == HOLD)  && bus.instr_ready;
  assign capture = (state == FETCH) && bus.imem_ack;
  assign pcplus4 = pc + 32'd4;

  // Redirect decisions only matter on accept; jump overrides branch.
  always_comb begin
    pc_nxt = pcplus4;
    if (bus.dojump)
      pc_nxt = jump_target(pcplus4, instr_q[25:0]);
    else if (bus.dobranch)
      pc_nxt = branch_target(pcplus4, instr_q[15:0]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pc      <= {RESET_PC[31:2], 2'b00};
      instr_q <= 32'h0;
      retired <= 32'h0;
    end else begin
      state <= state_nxt;
      if (capture)
        instr_q <= bus.imem_rdata;
      if (accept) begin
        pc      <= pc_nxt;
        retired <= retired + 32'd1;
      end
    end
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state == HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, memory wait, branch,
// jump priority, address wrap, backpressure and mid-operation reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic [31:0] retired;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] held;

  fetch_unit_if bus();

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.master),
    .pc      (pc),
    .pcplus4 (pcplus4),
    .retired (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while in FETCH: check request, return one word.
  task automatic fetch_word(input string tag, input logic [31:0] word);
    chk({tag, ".req"},  {31'b0, bus.imem_req}, 32'd1);
    chk({tag, ".addr"}, bus.imem_addr, exp_pc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    chk({tag, ".valid"}, {31'b0, bus.instr_valid}, 32'd1);
    chk({tag, ".instr"}, bus.instr, word);
  endtask

  // Called at a negedge while in HOLD: accept with the given decisions.
  task automatic accept_instr(input string tag, input logic br, input logic jp,
                              input logic [31:0] next_pc);
    bus.instr_ready = 1'b1;
    bus.dobranch    = br;
    bus.dojump      = jp;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.dobranch    = 1'b0;
    bus.dojump      = 1'b0;
    exp_pc  = next_pc;
    exp_ret = exp_ret + 32'd1;
    chk({tag, ".pc"},      pc, exp_pc);
    chk({tag, ".retired"}, retired, exp_ret);
    chk({tag, ".req"},     {31'b0, bus.imem_req}, 32'd1);
  endtask

  initial begin
    reset           = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.dobranch    = 1'b0;
    bus.dojump      = 1'b0;
    exp_pc  = 32'h0;
    exp_ret = 32'h0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.req",     {31'b0, bus.imem_req}, 32'd0);
    chk("rst.valid",   {31'b0, bus.instr_valid}, 32'd0);
    chk("rst.pc",      pc, 32'h0);
    chk("rst.instr",   bus.instr, 32'h0);
    chk("rst.retired", retired, 32'h0);

    // release: IDLE for one cycle, then FETCH
    reset = 1'b1;
    #1;
    chk("rel.req_idle", {31'b0, bus.imem_req}, 32'd0);
    @(negedge clk);

    // memory wait: five cycles with no ack
    for (int i = 0; i < 5; i++) begin
      chk("wait.req",   {31'b0, bus.imem_req}, 32'd1);
      chk("wait.addr",  bus.imem_addr, 32'h0);
      chk("wait.valid", {31'b0, bus.instr_valid}, 32'd0);
      bus.dobranch = 1'b1;
      @(negedge clk);
      bus.dobranch = 1'b0;
    end
    chk("wait.pc", pc, 32'h0);

    // sequential fetch 0x0, 0x4, 0x8, then 0xC
    fetch_word("seq0", 32'h0000_0001);
    chk("seq0.pcplus4", pcplus4, 32'h4);
    accept_instr("seq0", 1'b0, 1'b0, 32'h4);
    fetch_word("seq1", 32'h0000_0002);
    accept_instr("seq1", 1'b0, 1'b0, 32'h8);
    fetch_word("seq2", 32'h0000_0003);
    accept_instr("seq2", 1'b0, 1'b0, 32'hC);
    chk("seq.retired3", retired, 32'd3);
    fetch_word("seq3", 32'h0000_0004);
    accept_instr("seq3", 1'b0, 1'b0, 32'h10);

    // branches from 0x10: backward to 0x0C, then forward to 0x20
    fetch_word("br0", 32'h1000_FFFE);
    accept_instr("br0", 1'b1, 1'b0, 32'h0C);
    fetch_word("br1", 32'h0000_0000);
    accept_instr("br1", 1'b0, 1'b0, 32'h10);
    fetch_word("br2", 32'h1000_0003);
    accept_instr("br2", 1'b1, 1'b0, 32'h20);
    fetch_word("br3", 32'h1000_0003);
    accept_instr("br3", 1'b1, 1'b0, 32'h30);

    // jump beats branch
    fetch_word("jmp", 32'h0800_0100);
    accept_instr("jmp", 1'b1, 1'b1, 32'h400);

    // branch to the top word, then sequential wrap to zero
    fetch_word("top", 32'h1000_FEFE);
    accept_instr("top", 1'b1, 1'b0, 32'hFFFF_FFFC);
    chk("top.pcplus4", pcplus4, 32'h0);
    fetch_word("wrap", 32'h0000_0000);
    accept_instr("wrap", 1'b0, 1'b0, 32'h0);

    // backpressure: ready low for four HOLD cycles, branch/ack toggling
    held = 32'hCAFE_0004;
    fetch_word("bp", held);
    for (int i = 0; i < 4; i++) begin
      bus.dobranch = i[0];
      bus.dojump   = ~i[0];
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'h5555_0000 + i;
      @(negedge clk);
      chk("bp.instr",   bus.instr, held);
      chk("bp.pc",      pc, exp_pc);
      chk("bp.retired", retired, exp_ret);
      chk("bp.req",     {31'b0, bus.imem_req}, 32'd0);
      chk("bp.valid",   {31'b0, bus.instr_valid}, 32'd1);
    end
    bus.dobranch   = 1'b0;
    bus.dojump     = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    accept_instr("bp", 1'b0, 1'b0, 32'h4);

    // mid-operation reset in HOLD with ready and a redirect pending
    fetch_word("mrst", 32'h0800_0200);
    reset           = 1'b0;
    bus.instr_ready = 1'b1;
    bus.dojump      = 1'b1;
    bus.imem_ack    = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.dojump      = 1'b0;
    bus.imem_ack    = 1'b0;
    chk("mrst.pc",      pc, 32'h0);
    chk("mrst.retired", retired, 32'h0);
    chk("mrst.instr",   bus.instr, 32'h0);
    chk("mrst.valid",   {31'b0, bus.instr_valid}, 32'd0);
    chk("mrst.req",     {31'b0, bus.imem_req}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst.refetch_req",  {31'b0, bus.imem_req}, 32'd1);
    chk("mrst.refetch_addr", bus.imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
